// File: rtl/xs3_pkg.sv
// Shared excess-3 constants and FSM state type for the digit-serial adder.
package xs3_pkg;

  localparam logic [3:0] XS3_BIAS  = 4'b0011;
  localparam logic [3:0] XS3_NBIAS = 4'b1101;
  localparam logic [3:0] XS3_MIN   = 4'b0011;
  localparam logic [3:0] XS3_MAX   = 4'b1100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ADD  = 1'b1
  } state_t;

  function automatic logic xs3_illegal(input logic [3:0] dig);
    return (dig < XS3_MIN) || (dig > XS3_MAX);
  endfunction

endpackage

// File: rtl/xs3_serial_adder_if.sv
// Operand/result bundle for xs3_serial_adder; err exists only when XS3_CHECK_EN is defined.
interface xs3_serial_adder_if #(
  parameter int unsigned NDIG = 4
);

  logic                start;
  logic [4*NDIG-1:0]   a;
  logic [4*NDIG-1:0]   b;
  logic                busy;
  logic                sum_valid;
  logic [3:0]          sum_digit;
  logic [4*NDIG-1:0]   sum;
  logic                carry_out;
  logic                done;
`ifdef XS3_CHECK_EN
  logic                err;

  modport master (
    output start, a, b,
    input  busy, sum_valid, sum_digit, sum, carry_out, done, err
  );

  modport slave (
    input  start, a, b,
    output busy, sum_valid, sum_digit, sum, carry_out, done, err
  );
`else
  modport master (
    output start, a, b,
    input  busy, sum_valid, sum_digit, sum, carry_out, done
  );

  modport slave (
    input  start, a, b,
    output busy, sum_valid, sum_digit, sum, carry_out, done
  );
`endif

endinterface

// File: rtl/xs3_digit_add.sv
// Combinational single-digit excess-3 adder: binary add, then re-bias by +3 or -3.
module xs3_digit_add
  import xs3_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_d,
  output logic       o_cout
);

  logic [4:0] w_t;

  always_comb begin
    w_t    = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
    o_cout = w_t[4];
    o_d    = w_t[3:0] + (w_t[4] ? XS3_BIAS : XS3_NBIAS);
  end

endmodule

// File: rtl/xs3_serial_adder.sv
// Digit-serial excess-3 adder, LSD first, one digit per clock.
// Optional XS3_CHECK_EN adds a sticky illegal-code flag (err).
module xs3_serial_adder
  import xs3_pkg::*;
#(
  parameter int unsigned NDIG = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  xs3_serial_adder_if.slave  bus
);

  localparam int unsigned W    = 4 * NDIG;
  localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NDIG - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_sum;
  logic [3:0]      r_sum_digit;
  logic            r_sum_valid;
  logic            r_carry_out;
  logic            r_done;
  logic            w_accept;
  logic            w_last;
  logic [3:0]      w_d;
  logic            w_cout;

  xs3_digit_add u_digit_add (
    .i_a    (r_a[3:0]),
    .i_b    (r_b[3:0]),
    .i_cin  (r_carry),
    .o_d    (w_d),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = (r_idx == LAST);
    case (r_state)
      S_IDLE: begin
        w_accept = bus.start;
        if (bus.start) w_state_nxt = S_ADD;
      end
      S_ADD: begin
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands shift right so the digit under work is always in bits [3:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_sum_digit <= '0;
      r_sum_valid <= 1'b0;
      r_carry_out <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_sum_valid <= 1'b0;
      r_done      <= 1'b0;
      if (w_accept) begin
        r_a     <= bus.a;
        r_b     <= bus.b;
        r_carry <= 1'b0;
        r_idx   <= '0;
        r_sum   <= '0;
      end else if (r_state == S_ADD) begin
        r_sum_digit <= w_d;
        r_sum_valid <= 1'b1;
        for (int unsigned i = 0; i < NDIG; i++) begin
          if (r_idx == IDXW'(i)) r_sum[4*i +: 4] <= w_d;
        end
        r_carry <= w_cout;
        r_a     <= r_a >> 4;
        r_b     <= r_b >> 4;
        r_idx   <= r_idx + IDXW'(1);
        if (w_last) begin
          r_carry_out <= w_cout;
          r_done      <= 1'b1;
        end
      end
    end
  end

`ifdef XS3_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (r_state == S_ADD) begin
      if (xs3_illegal(r_a[3:0]) || xs3_illegal(r_b[3:0])) r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`endif

  assign bus.busy      = (r_state == S_ADD);
  assign bus.sum_valid = r_sum_valid;
  assign bus.sum_digit = r_sum_digit;
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_carry_out;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_xs3_serial_adder.sv
// Directed self-checking bench for xs3_serial_adder (NDIG=4), with the err case under XS3_CHECK_EN.
module tb_xs3_serial_adder;

  localparam int unsigned NDIG = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  xs3_serial_adder_if #(.NDIG(NDIG)) bus ();

  xs3_serial_adder #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    edge_sample();
    chk("accept_busy", {31'd0, bus.busy}, 32'd1);
    chk("accept_sum_clr", {16'd0, bus.sum}, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_sum, input logic exp_cout);
    logic [15:0] s;
    s = exp_sum;
    accept(a, b);
    for (int k = 1; k <= 4; k++) begin
      edge_sample();
      chk({tag, "_valid"}, {31'd0, bus.sum_valid}, 32'd1);
      chk({tag, "_digit"}, {28'd0, bus.sum_digit}, {28'd0, s[4*(k-1) +: 4]});
      chk({tag, "_done"}, {31'd0, bus.done}, (k == 4) ? 32'd1 : 32'd0);
      chk({tag, "_busy"}, {31'd0, bus.busy}, (k == 4) ? 32'd0 : 32'd1);
    end
    chk({tag, "_sum"}, {16'd0, bus.sum}, {16'd0, exp_sum});
    chk({tag, "_cout"}, {31'd0, bus.carry_out}, {31'd0, exp_cout});
    edge_sample();
    chk({tag, "_valid_after"}, {31'd0, bus.sum_valid}, 32'd0);
    chk({tag, "_done_after"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_sum_hold"}, {16'd0, bus.sum}, {16'd0, exp_sum});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.sum_valid}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_cout"}, {31'd0, bus.carry_out}, 32'd0);
    chk({tag, "_digit"}, {28'd0, bus.sum_digit}, 32'd0);
    chk({tag, "_sum"}, {16'd0, bus.sum}, 32'd0);
  endtask

  initial begin
    int nvalid;
    int ndone;
    n_checks  = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1234 + 5678 = 6912
    run_add("add1", 16'h4567, 16'h89AB, 16'h9C45, 1'b0);
    // 9999 + 0001 = 10000
    run_add("add2", 16'hCCCC, 16'h3334, 16'h3333, 1'b1);

    // Reset mid-add after E2
    accept(16'h4567, 16'h89AB);
    edge_sample();
    edge_sample();
    chk("mid_valid", {31'd0, bus.sum_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_add("postrst", 16'h4567, 16'h89AB, 16'h9C45, 1'b0);

    // start held high: second add accepted in the done cycle
    nvalid = 0;
    ndone  = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h4567;
    bus.b     = 16'h89AB;
    edge_sample();
    for (int i = 1; i <= 12; i++) begin
      edge_sample();
      if (bus.sum_valid) nvalid++;
      if (bus.done) ndone++;
      if (i == 5) begin
        chk("b2b_gap_valid", {31'd0, bus.sum_valid}, 32'd0);
        chk("b2b_reaccept", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    chk("b2b_nvalid", nvalid, 32'd8);
    chk("b2b_ndone", ndone, 32'd2);
    chk("b2b_sum", {16'd0, bus.sum}, 32'h9C45);

    // start with other operands while busy is ignored
    accept(16'hCCCC, 16'h3334);
    edge_sample();
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h5555;
    bus.b     = 16'h5555;
    @(negedge clk);
    bus.start = 1'b0;
    edge_sample();
    edge_sample();
    chk("ign_done", {31'd0, bus.done}, 32'd1);
    chk("ign_sum", {16'd0, bus.sum}, 32'h3333);
    chk("ign_cout", {31'd0, bus.carry_out}, 32'd1);
    edge_sample();
    chk("ign_idle", {31'd0, bus.busy}, 32'd0);
    run_add("add3", 16'h5555, 16'h5555, 16'h7777, 1'b0);

`ifdef XS3_CHECK_EN
    chk("err_init", {31'd0, bus.err}, 32'd0);
    accept(16'h4561, 16'h3333);
    edge_sample();
    chk("err_e1", {31'd0, bus.err}, 32'd1);
    repeat (3) edge_sample();
    chk("err_sticky", {31'd0, bus.err}, 32'd1);
    accept(16'h4567, 16'h89AB);
    chk("err_clear", {31'd0, bus.err}, 32'd0);
    repeat (4) edge_sample();
    chk("err_legal", {31'd0, bus.err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
